// File: rtl/acc8_frame_sequencer.sv
// Frame sequencer around an external 8-bit combinational adder: feeds the running sum
// and incoming term to the adder, accumulates its sum, and emits one sum+wrap per frame.
module acc8_frame_sequencer #(
  parameter int FRAME_LEN = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] add_a,
  output logic [7:0] add_b,
  input  logic [7:0] add_sum,
  output logic [7:0] out_data,
  output logic       out_wrap,
  output logic       out_valid,
  input  logic       out_ready
);

  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;
  localparam logic [7:0] LAST  = 8'(FRAME_LEN - 1);

  logic [0:0] state;
  logic [7:0] acc;
  logic [7:0] cnt;
  logic       wrap;

  assign in_ready  = (state == ACCUM) && !clear;
  assign out_valid = (state == HOLD);
  assign out_data  = acc;
  assign out_wrap  = wrap;
  assign add_a     = acc;
  assign add_b     = in_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
      acc   <= '0;
      cnt   <= '0;
      wrap  <= 1'b0;
    end else if (clear) begin
      // Abort wins over any handshake: pending result and presented term are dropped.
      state <= ACCUM;
      acc   <= '0;
      cnt   <= '0;
      wrap  <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_valid) begin
            acc  <= add_sum;
            // Sum smaller than the addend means the 8-bit add carried out.
            wrap <= wrap | (add_sum < in_data);
            if (cnt == LAST) begin
              cnt   <= '0;
              state <= HOLD;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end
        default: begin
          if (out_ready) begin
            acc   <= '0;
            wrap  <= 1'b0;
            state <= ACCUM;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acc8_frame_sequencer.sv
// Bench for acc8_frame_sequencer: models the external adder, tracks the expected frame
// sum as a plain integer, and compares every DUT output on every cycle.
module tb_acc8_frame_sequencer;

  localparam int FL = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] add_a;
  logic [7:0] add_b;
  logic [7:0] add_sum;
  logic [7:0] out_data;
  logic       out_wrap;
  logic       out_valid;
  logic       out_ready;

  always #5 clk = ~clk;

  // External adder, purely combinational.
  assign add_sum = add_a + add_b;

  acc8_frame_sequencer #(.FRAME_LEN(FL)) u_dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .out_data(out_data), .out_wrap(out_wrap), .out_valid(out_valid), .out_ready(out_ready)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Model: true integer sum of the frame's accepted terms, count, and whether a result is held.
  int m_sum = 0;
  int m_n = 0;
  bit m_hold = 1'b0;

  task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sum = 0;
    m_n = 0;
    m_hold = 1'b0;
  endtask

  task automatic check_model();
    cmp("in_ready",  {7'd0, in_ready},  {7'd0, (!m_hold && !clear)});
    cmp("out_valid", {7'd0, out_valid}, {7'd0, m_hold});
    cmp("out_data",  out_data, 8'(m_sum % 256));
    cmp("out_wrap",  {7'd0, out_wrap},  {7'd0, (m_sum >= 256)});
    cmp("add_a",     add_a, 8'(m_sum % 256));
    cmp("add_b",     add_b, in_data);
  endtask

  // Drive one cycle's inputs, check outputs, advance the model, end at the next negedge.
  task automatic cyc(input bit clr, input bit iv, input logic [7:0] d, input bit ordy);
    clear = clr; in_valid = iv; in_data = d; out_ready = ordy;
    #1;
    check_model();
    if (clr) model_reset();
    else if (m_hold) begin
      if (ordy) begin m_sum = 0; m_hold = 1'b0; end
    end else if (iv) begin
      m_sum += int'(d);
      m_n++;
      if (m_n == FL) begin m_hold = 1'b1; m_n = 0; end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send4(input logic [7:0] a, b, c, e, input bit ordy);
    cyc(0, 1, a, ordy); cyc(0, 1, b, ordy); cyc(0, 1, c, ordy); cyc(0, 1, e, ordy);
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b0;
    #12;
    cmp("rst_in_ready", {7'd0, in_ready}, 8'd1);
    cmp("rst_out_valid", {7'd0, out_valid}, 8'd0);
    cmp("rst_out_data", out_data, 8'd0);
    cmp("rst_add_a", add_a, 8'd0);
    check_model();
    @(negedge clk);
    rst_n = 1'b1;

    // Basic frame, handoff cycle blocks input
    send4(1, 2, 3, 4, 1);
    cmp("t1_valid", {7'd0, out_valid}, 8'd1);
    cmp("t1_data", out_data, 8'h0A);
    cmp("t1_wrap", {7'd0, out_wrap}, 8'd0);
    cmp("t1_in_ready", {7'd0, in_ready}, 8'd0);
    cyc(0, 1, 8'd99, 1);
    cmp("t1_after_valid", {7'd0, out_valid}, 8'd0);
    cmp("t1_after_add_a", add_a, 8'd0);

    // Wrap, then wrap cleared by the next frame
    send4(200, 100, 0, 0, 0);
    cmp("t2_data", out_data, 8'h2C);
    cmp("t2_wrap", {7'd0, out_wrap}, 8'd1);
    cyc(0, 0, 8'd0, 1);
    send4(5, 5, 5, 5, 0);
    cmp("t2b_data", out_data, 8'd20);
    cmp("t2b_wrap", {7'd0, out_wrap}, 8'd0);
    cyc(0, 0, 8'd0, 1);

    // Backpressure: result held, terms refused
    send4(1, 1, 1, 1, 0);
    for (int i = 0; i < 6; i++) begin
      cyc(0, 1, 8'(8'd50 + i), 0);
      cmp("bp_valid", {7'd0, out_valid}, 8'd1);
      cmp("bp_data", out_data, 8'd4);
      cmp("bp_add_a", add_a, 8'd4);
      cmp("bp_in_ready", {7'd0, in_ready}, 8'd0);
    end
    cyc(0, 0, 8'd0, 1);
    cmp("bp_after_valid", {7'd0, out_valid}, 8'd0);
    cmp("bp_after_add_a", add_a, 8'd0);

    // Gapped input
    cyc(0, 1, 10, 0); cyc(0, 0, 77, 0); cyc(0, 1, 20, 0); cyc(0, 0, 77, 0);
    cyc(0, 1, 30, 0); cyc(0, 0, 77, 0);
    cmp("gap_not_done", {7'd0, out_valid}, 8'd0);
    cyc(0, 1, 40, 0);
    cmp("gap_valid", {7'd0, out_valid}, 8'd1);
    cmp("gap_data", out_data, 8'd100);
    cyc(0, 0, 8'd0, 1);

    // Clear mid-frame, with a term presented in the clear cycle
    cyc(0, 1, 7, 0); cyc(0, 1, 9, 0);
    cyc(1, 1, 55, 0);
    send4(1, 1, 1, 1, 0);
    cmp("clr_data", out_data, 8'd4);
    cmp("clr_valid", {7'd0, out_valid}, 8'd1);
    // Clear while holding discards the result
    cyc(1, 0, 8'd0, 0);
    cmp("clrh_valid", {7'd0, out_valid}, 8'd0);
    cmp("clrh_add_a", add_a, 8'd0);

    // Asynchronous reset mid-frame
    cyc(0, 1, 200, 0); cyc(0, 1, 100, 0); cyc(0, 1, 50, 0);
    cmp("pre_rst_wrap", {7'd0, out_wrap}, 8'd1);
    #2;
    rst_n = 1'b0;
    #1;
    cmp("arst_valid", {7'd0, out_valid}, 8'd0);
    cmp("arst_data", out_data, 8'd0);
    cmp("arst_wrap", {7'd0, out_wrap}, 8'd0);
    model_reset();
    check_model();
    @(negedge clk);
    rst_n = 1'b1;
    send4(2, 2, 2, 2, 0);
    cmp("arst_frame", out_data, 8'd8);
    cyc(0, 0, 8'd0, 1);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++)
      cyc(($urandom % 25) == 0, ($urandom % 4) != 0, 8'($urandom), ($urandom % 3) != 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
